digit_scan_ctrl: RTL and testbench

//   Time-multiplexed scan driver for the 4-digit seven-segment display.
//   - Holds a 16-bit display value and steps the digit index 0..3.
//   - Drives the digit select and nibble into the segment decoder.
//   - Gates the anode enables and inserts a blanking gap between digits to prevent ghosting.
//   - New values are double-buffered and committed only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/digit_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 4-digit seven-segment scan driver with frame-committed value buffer
//
// Purpose:
//    Steps the digit index 0..3. Each digit is lit for CLK_DIV cycles (SHOW) and
//    then followed by BLANK_CYCLES cycles with every anode off (BLANK). A loaded
//    value waits in a pending buffer. It is committed to the displayed value only
//    on the BLANK->SHOW edge where the index wraps 3->0, so a frame never mixes
//    old and new digits.
//    Optional macro LEADING_ZERO_SUPPRESS_EN keeps leading zero digits 3..1 dark.
//
// Ports:
//    clk        in   rising-edge clock
//    reset_n    in   synchronous reset, active low
//    enable_i   in   1 = scan runs, 0 = scan held in its reset state
//    value_i    in   16-bit value to display (digit k = value_i[4k+3:4k])
//    load_i     in   1-cycle strobe that captures value_i into the pending buffer
//    pending_o  out  a loaded value is waiting for the next frame commit
//    ano_o      out  current digit index
//    digit_o    out  nibble of the displayed value for digit ano_o
//    an_o       out  one-hot anode enable, active high
//    blank_o    out  1 while all anodes are off
//    frame_o    out  1-cycle pulse on the first cycle digit 0 is shown
module digit_scan_ctrl #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable_i,
   input  logic [15:0] value_i,
   input  logic        load_i,
   output logic        pending_o,
   output logic [1:0]  ano_o,
   output logic [3:0]  digit_o,
   output logic [3:0]  an_o,
   output logic        blank_o,
   output logic        frame_o
);

   localparam int MAXC  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {ST_SHOW = 1'b0, ST_BLANK = 1'b1} state_t;

   state_t             r_state;
   logic [1:0]         r_idx;
   logic [CNT_W-1:0]   r_cnt;
   logic [15:0]        r_disp;
   logic [15:0]        r_pend;
   logic               r_pend_v;

   state_t             w_state_nx;
   logic [1:0]         w_idx_nx;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic [15:0]        w_disp_nx;
   logic [15:0]        w_pend_nx;
   logic               w_pend_v_nx;
   logic               w_commit;
   logic               w_suppress;
   logic               w_lit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_BLANK;
         r_idx    <= 2'd3;
         r_cnt    <= '0;
         r_disp   <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_idx    <= w_idx_nx;
         r_cnt    <= w_cnt_nx;
         r_disp   <= w_disp_nx;
         r_pend   <= w_pend_nx;
         r_pend_v <= w_pend_v_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_cnt_nx    = r_cnt;
      w_disp_nx   = r_disp;
      w_pend_nx   = r_pend;
      w_pend_v_nx = r_pend_v;
      w_commit    = 1'b0;

      if (!enable_i) begin
         // Parked in the reset position so re-enable starts a fresh frame.
         w_state_nx = ST_BLANK;
         w_idx_nx   = 2'd3;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            ST_SHOW: begin
               if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                  w_state_nx = ST_BLANK;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                  w_state_nx = ST_SHOW;
                  w_cnt_nx   = '0;
                  w_idx_nx   = r_idx + 2'd1;
                  w_commit   = (r_idx == 2'd3);
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
         endcase
      end

      if (w_commit) begin
         // A load landing on the commit edge bypasses the buffer and wins over it.
         if (load_i) begin
            w_disp_nx   = value_i;
            w_pend_v_nx = 1'b0;
         end else if (r_pend_v) begin
            w_disp_nx   = r_pend;
            w_pend_v_nx = 1'b0;
         end
      end else if (load_i) begin
         w_pend_nx   = value_i;
         w_pend_v_nx = 1'b1;
      end
   end

`ifdef LEADING_ZERO_SUPPRESS_EN
   // Dark when this nibble and every higher nibble are zero; digit 0 always lights.
   always_comb begin
      w_suppress = 1'b0;
      case (r_idx)
         2'd3:    w_suppress = (r_disp[15:12] == 4'd0);
         2'd2:    w_suppress = (r_disp[15:8]  == 8'd0);
         2'd1:    w_suppress = (r_disp[15:4]  == 12'd0);
         default: w_suppress = 1'b0;
      endcase
   end
`else
   assign w_suppress = 1'b0;
`endif

   assign w_lit     = (r_state == ST_SHOW) && !w_suppress;
   assign an_o      = w_lit ? (4'b0001 << r_idx) : 4'b0000;
   assign blank_o   = !w_lit;
   assign ano_o     = r_idx;
   assign digit_o   = r_disp[{r_idx, 2'b00} +: 4];
   assign frame_o   = (r_state == ST_SHOW) && (r_idx == 2'd0) && (r_cnt == '0);
   assign pending_o = r_pend_v;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;

   localparam int CD = 4;
   localparam int BC = 2;
   localparam int P  = CD + BC;
   localparam int F  = 4 * P;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable_i;
   logic [15:0] value_i;
   logic        load_i;
   logic        pending_o;
   logic [1:0]  ano_o;
   logic [3:0]  digit_o;
   logic [3:0]  an_o;
   logic        blank_o;
   logic        frame_o;

   int n_vec = 0;
   int n_err = 0;

   digit_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable_i  (enable_i),
      .value_i   (value_i),
      .load_i    (load_i),
      .pending_o (pending_o),
      .ano_o     (ano_o),
      .digit_o   (digit_o),
      .an_o      (an_o),
      .blank_o   (blank_o),
      .frame_o   (frame_o)
   );

   always #5 clk = ~clk;

   // Model: m_s is cycles elapsed since the scan last (re)started.
   int          m_s = 0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_pend = 16'h0;
   logic        m_pendv = 1'b0;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      int ns;
      m_valid = 1'b1;
      if (!reset_n) begin
         m_s = 0; m_disp = 16'h0; m_pendv = 1'b0;
      end else if (!enable_i) begin
         m_s = 0;
         if (load_i) begin m_pend = value_i; m_pendv = 1'b1; end
      end else begin
         ns = m_s + 1;
         if (ns >= BC && ((ns - BC) % F) == 0) begin
            if (load_i) begin m_disp = value_i; m_pendv = 1'b0; end
            else if (m_pendv) begin m_disp = m_pend; m_pendv = 1'b0; end
         end else if (load_i) begin
            m_pend = value_i; m_pendv = 1'b1;
         end
         m_s = ns;
      end
   end

   int          e_q, e_d;
   logic        e_show, e_lit, e_frame;
   logic [3:0]  e_an, e_digit;
   logic [15:0] e_hi;

   always @(negedge clk) begin
      if (m_valid) begin
         if (m_s < BC) begin
            e_d = 3; e_show = 1'b0; e_q = -1;
         end else begin
            e_q = (m_s - BC) % F;
            e_d = e_q / P;
            e_show = (e_q % P) < CD;
         end
         e_frame = e_show && (e_q == 0);
         e_digit = 4'((m_disp >> (4 * e_d)) & 16'hF);
         e_hi    = m_disp >> (4 * e_d);
         e_lit   = e_show;
`ifdef LEADING_ZERO_SUPPRESS_EN
         if (e_d > 0 && e_hi == 16'h0) e_lit = 1'b0;
`endif
         e_an = e_lit ? 4'(1 << e_d) : 4'b0000;
         n_vec++;
         if (an_o !== e_an || blank_o !== !e_lit || ano_o !== 2'(e_d) ||
             digit_o !== e_digit || frame_o !== e_frame || pending_o !== m_pendv) begin
            n_err++;
            $display("FAIL model s=%0d: got an=%b blank=%b ano=%0d digit=%h frame=%b pend=%b, want an=%b blank=%b ano=%0d digit=%h frame=%b pend=%b",
                     m_s, an_o, blank_o, ano_o, digit_o, frame_o, pending_o,
                     e_an, !e_lit, e_d, e_digit, e_frame, m_pendv);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; enable_i = 1'b1; value_i = 16'h0; load_i = 1'b0;
      // 1. reset hold, then first frame two edges after release
      cyc(3);
      chk("rst_an", 16'(an_o), 16'h0);
      chk("rst_blank", 16'(blank_o), 16'h1);
      chk("rst_ano", 16'(ano_o), 16'h3);
      chk("rst_frame", 16'(frame_o), 16'h0);
      chk("rst_pend", 16'(pending_o), 16'h0);
      reset_n = 1'b1;                             // s = 0
      cyc(1);
      chk("rel_noframe", 16'(frame_o), 16'h0);
      cyc(1);                                     // s = 2
      chk("rel_frame", 16'(frame_o), 16'h1);
      chk("rel_an", 16'(an_o), 16'h1);
      // 2. load 0x1234 mid-frame, commit at s = 26
      cyc(3);
      value_i = 16'h1234; load_i = 1'b1;
      cyc(1);                                     // s = 6
      load_i = 1'b0;
      chk("ld_pend", 16'(pending_o), 16'h1);
      chk("ld_nochange", 16'(digit_o), 16'h0);
      cyc(20);                                    // s = 26
      chk("c1_frame", 16'(frame_o), 16'h1);
      chk("c1_pend", 16'(pending_o), 16'h0);
      chk("c1_d0", 16'(digit_o), 16'h4);
      cyc(6);                                     // s = 32
      chk("c1_d1", 16'(digit_o), 16'h3);
      chk("c1_an1", 16'(an_o), 16'h2);
      cyc(4);                                     // s = 36
      chk("c1_gap", 16'(an_o), 16'h0);
      cyc(2);                                     // s = 38
      chk("c1_d2", 16'(digit_o), 16'h2);
      chk("c1_an2", 16'(an_o), 16'h4);
      cyc(6);                                     // s = 44
      chk("c1_d3", 16'(digit_o), 16'h1);
      chk("c1_an3", 16'(an_o), 16'h8);
      // 3. last load in a frame wins
      value_i = 16'hAAAA; load_i = 1'b1;
      cyc(1);
      value_i = 16'h5555;
      cyc(1);                                     // s = 46
      load_i = 1'b0;
      cyc(4);                                     // s = 50
      chk("lw_d0", 16'(digit_o), 16'h5);
      cyc(6);                                     // s = 56
      chk("lw_d1", 16'(digit_o), 16'h5);
      // 4. load exactly on the commit edge (s 73 -> 74)
      cyc(17);                                    // s = 73
      value_i = 16'h00C7; load_i = 1'b1;
      cyc(1);                                     // s = 74
      load_i = 1'b0;
      chk("by_frame", 16'(frame_o), 16'h1);
      chk("by_d0", 16'(digit_o), 16'h7);
      chk("by_pend", 16'(pending_o), 16'h0);
      cyc(6);                                     // s = 80
      chk("by_d1", 16'(digit_o), 16'hC);
      cyc(6);                                     // s = 86, digit 2 SHOW
      // 5. drop enable during digit 2 SHOW
      cyc(1);
      enable_i = 1'b0;
      cyc(1);
      chk("dis_an", 16'(an_o), 16'h0);
      chk("dis_ano", 16'(ano_o), 16'h3);
      cyc(3);
      enable_i = 1'b1;
      cyc(1);
      chk("ren_noframe", 16'(frame_o), 16'h0);
      cyc(1);                                     // s = 2
      chk("ren_frame", 16'(frame_o), 16'h1);
      chk("ren_d0", 16'(digit_o), 16'h7);
      // 6. leading zeros: 0x0050
      value_i = 16'h0050; load_i = 1'b1;
      cyc(1);
      load_i = 1'b0;
      cyc(23);                                    // s = 26
      chk("lz_d0", 16'(digit_o), 16'h0);
      chk("lz_an0", 16'(an_o), 16'h1);
      cyc(6);                                     // s = 32
      chk("lz_d1", 16'(digit_o), 16'h5);
      chk("lz_an1", 16'(an_o), 16'h2);
      cyc(6);                                     // s = 38
`ifdef LEADING_ZERO_SUPPRESS_EN
      chk("lz_an2", 16'(an_o), 16'h0);
`else
      chk("lz_an2", 16'(an_o), 16'h4);
`endif
      cyc(6);                                     // s = 44
`ifdef LEADING_ZERO_SUPPRESS_EN
      chk("lz_an3", 16'(an_o), 16'h0);
`else
      chk("lz_an3", 16'(an_o), 16'h8);
`endif
      value_i = 16'h0000; load_i = 1'b1;
      cyc(1);
      load_i = 1'b0;
      cyc(F + 4);
      // reset mid-frame drops pending value and clears disp
      value_i = 16'h9999; load_i = 1'b1;
      cyc(1);
      load_i = 1'b0;
      reset_n = 1'b0;
      cyc(1);
      chk("mrst_pend", 16'(pending_o), 16'h0);
      chk("mrst_digit", 16'(digit_o), 16'h0);
      reset_n = 1'b1;
      cyc(F + 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
